// File: rtl/unidade_controle.sv
// Multicycle control unit for the RV64 subset datapath: sequences PC/IR/register bank/memory and mux selects.
// Optional performance counters are built when UC_PERF_EN is defined.
module unidade_controle #(
  parameter int COUNT_W        = 32,
  parameter bit START_ON_RESET = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        palavra,
  input  logic               flag,
  output logic               pc_en,
  output logic               ir_en,
  output logic               reg_we,
  output logic               mem_we,
  output logic               sel_mux1,
  output logic               sel_mux2,
  output logic               sel_mux3,
  output logic               busy,
  output logic               illegal,
  output logic [2:0]         estado,
  output logic [COUNT_W-1:0] cyc_count,
  output logic [COUNT_W-1:0] ins_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam state_t RESET_STATE = START_ON_RESET ? S_FETCH : S_IDLE;

  state_t state_reg, state_next, boundary;
  logic   illegal_reg, set_illegal, retire;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_r, is_addi, is_load, is_store, is_branch, legal;
  logic       unused_ok;

  assign opcode = palavra[6:0];
  assign funct3 = palavra[14:12];
  assign funct7 = palavra[31:25];
  // Register and immediate fields belong to the datapath, not to sequencing.
  assign unused_ok = ^{palavra[24:15], palavra[11:7]};

  assign is_r      = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                     ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
  assign is_addi   = (opcode == 7'b0010011) && (funct3 == 3'b000);
  assign is_load   = (opcode == 7'b0000011);
  assign is_store  = (opcode == 7'b0100011);
  assign is_branch = (opcode == 7'b1100011) && (funct3 != 3'b010) && (funct3 != 3'b011);
  assign legal     = is_r | is_addi | is_load | is_store | is_branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RESET_STATE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (set_illegal) illegal_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    boundary    = stop ? S_IDLE : S_FETCH;
    set_illegal = 1'b0;
    retire      = 1'b0;
    pc_en       = 1'b0;
    ir_en       = 1'b0;
    reg_we      = 1'b0;
    mem_we      = 1'b0;
    sel_mux1    = 1'b0;
    sel_mux2    = 1'b0;
    sel_mux3    = 1'b0;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_FETCH;
      S_FETCH: begin
        ir_en      = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        if (legal) begin
          state_next = S_EXECUTE;
        end else begin
          state_next  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_EXECUTE: begin
        sel_mux1 = is_r | is_branch;
        if (is_branch) begin
          pc_en      = 1'b1;
          sel_mux3   = flag;
          retire     = 1'b1;
          state_next = boundary;
        end else if (is_load || is_store) begin
          state_next = S_MEMORY;
        end else if (is_r || is_addi) begin
          state_next = S_WRITEBACK;
        end else begin
          state_next = S_HALT;
        end
      end
      S_MEMORY: begin
        if (is_store) begin
          mem_we     = 1'b1;
          pc_en      = 1'b1;
          retire     = 1'b1;
          state_next = boundary;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        pc_en      = 1'b1;
        sel_mux1   = is_r;  // keeps the ULA operand as in EXECUTE so soma is stable
        sel_mux2   = ~is_load;
        retire     = 1'b1;
        state_next = boundary;
      end
      S_HALT:  state_next = S_HALT;
      default: state_next = S_HALT;
    endcase
    // Reset must kill any in-flight write strobe at once, not at the next edge.
    if (!rst_n) begin
      pc_en    = 1'b0;
      ir_en    = 1'b0;
      reg_we   = 1'b0;
      mem_we   = 1'b0;
      sel_mux1 = 1'b0;
      sel_mux2 = 1'b0;
      sel_mux3 = 1'b0;
    end
  end

  assign busy    = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign illegal = illegal_reg;
  assign estado  = state_reg;

`ifdef UC_PERF_EN
  logic [COUNT_W-1:0] cyc_count_reg, ins_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_count_reg <= '0;
      ins_count_reg <= '0;
    end else begin
      if (busy)   cyc_count_reg <= cyc_count_reg + 1'b1;
      if (retire) ins_count_reg <= ins_count_reg + 1'b1;
    end
  end

  assign cyc_count = cyc_count_reg;
  assign ins_count = ins_count_reg;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cyc_count     = '0;
  assign ins_count     = '0;
`endif

endmodule
